// File: rtl/control_fsm.sv
// control_fsm
// Moore sequencer for a multicycle LC-3b style datapath. It handles
// fetch, decode, ADD/AND/NOT, BR, LDR and STR. Every output decodes from
// the current state only.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   opcode[3:0]          IR[15:12]
//   branch_enable        CC matches the IR nzp field
//   mem_resp             memory finishes the current read/write this cycle
//   pcmux_sel .. mdrmux_sel, load_*   datapath mux selects and register loads
//   aluop[2:0]           ALU operation (add=0, and=1, not=2, pass=3)
//   mem_read, mem_write  memory requests, held until mem_resp
//   mem_byte_enable[1:0] always 2'b11 (word accesses only)
//
// state     | meaning
// ----------+------------------------------------------------
// FETCH1    | MAR <- PC
// FETCH2    | read memory into MDR, wait for mem_resp
// FETCH3    | IR <- MDR, PC <- PC+2
// DECODE    | dispatch on opcode; unsupported opcodes act as NOP
// S_ADD     | DR <- SR1 + SR2, update CC
// S_AND     | DR <- SR1 & SR2, update CC
// S_NOT     | DR <- ~SR1, update CC
// BR        | test branch_enable
// BR_TAKEN  | PC <- branch target
// CALC_ADDR | MAR <- base + sext(offset6)<<1
// LDR1      | read memory into MDR, wait for mem_resp
// LDR2      | DR <- MDR, update CC
// STR1      | MDR <- SR (port A selects IR[11:9])
// STR2      | write memory, wait for mem_resp
module control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       pcmux_sel,
  output logic       load_pc,
  output logic       storemux_sel,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam logic [3:0] op_br  = 4'b0000;
  localparam logic [3:0] op_add = 4'b0001;
  localparam logic [3:0] op_and = 4'b0101;
  localparam logic [3:0] op_not = 4'b1001;
  localparam logic [3:0] op_ldr = 4'b0110;
  localparam logic [3:0] op_str = 4'b0111;

  localparam logic [2:0] alu_add  = 3'd0;
  localparam logic [2:0] alu_and  = 3'd1;
  localparam logic [2:0] alu_not  = 3'd2;
  localparam logic [2:0] alu_pass = 3'd3;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT,
    BR, BR_TAKEN,
    CALC_ADDR, LDR1, LDR2, STR1, STR2
  } state_t;

  state_t state, state_next;

  assign mem_byte_enable = 2'b11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH1;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    pcmux_sel      = 1'b0;
    load_pc        = 1'b0;
    storemux_sel   = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    alumux_sel     = 1'b0;
    regfilemux_sel = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    aluop          = alu_add;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    case (state)
      FETCH1: begin
        marmux_sel = 1'b1;
        load_mar   = 1'b1;
        state_next = FETCH2;
      end
      FETCH2: begin
        mdrmux_sel = 1'b1;
        load_mdr   = 1'b1;
        mem_read   = 1'b1;
        if (mem_resp) state_next = FETCH3;
      end
      FETCH3: begin
        load_ir    = 1'b1;
        load_pc    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          op_add:         state_next = S_ADD;
          op_and:         state_next = S_AND;
          op_not:         state_next = S_NOT;
          op_br:          state_next = BR;
          op_ldr, op_str: state_next = CALC_ADDR;
          default:        state_next = FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        if (state == S_AND)      aluop = alu_and;
        else if (state == S_NOT) aluop = alu_not;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        state_next   = FETCH1;
      end
      BR: begin
        state_next = branch_enable ? BR_TAKEN : FETCH1;
      end
      BR_TAKEN: begin
        pcmux_sel  = 1'b1;
        load_pc    = 1'b1;
        state_next = FETCH1;
      end
      CALC_ADDR: begin
        alumux_sel = 1'b1;
        load_mar   = 1'b1;
        if (opcode == op_ldr)      state_next = LDR1;
        else if (opcode == op_str) state_next = STR1;
        else                       state_next = FETCH1;
      end
      LDR1: begin
        mdrmux_sel = 1'b1;
        load_mdr   = 1'b1;
        mem_read   = 1'b1;
        if (mem_resp) state_next = LDR2;
      end
      LDR2: begin
        regfilemux_sel = 1'b1;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
        state_next     = FETCH1;
      end
      STR1: begin
        storemux_sel = 1'b1;
        aluop        = alu_pass;
        load_mdr     = 1'b1;
        state_next   = STR2;
      end
      STR2: begin
        mem_write = 1'b1;
        if (mem_resp) state_next = FETCH1;
      end
      default: state_next = FETCH1;
    endcase
  end

endmodule
